// File: rtl/serial_mult4_if.sv
// serial_mult4_if
//   Operand/result bundle for the serial_mult4 shift-and-add multiplier.
//   Clock and the reset/start strobe stay as plain ports on the multiplier.
//
//   Signals:
//     a     WIDTH    multiplicand, unsigned (driven by master)
//     b     WIDTH    multiplier, unsigned (driven by master)
//     prod  2*WIDTH  registered product (driven by slave)
//
//   Modports:
//     master : the client that supplies operands and reads the product
//     slave  : the multiplier itself
interface serial_mult4_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] prod;

  modport master (output a, output b, input prod);
  modport slave  (input a, input b, output prod);
endinterface

// File: rtl/serial_mult4.sv
// serial_mult4
//   Shift-and-add serial multiplier. Computes the unsigned product of two
//   WIDTH-bit operands, consuming one multiplier bit per clock.
//
//   The synchronous active-high reset doubles as the start strobe: every
//   edge with rst=1 captures a new operand pair and clears the result.
//   The product appears WIDTH edges after the last loading edge and is held
//   until the next reset.
//
//   Ports:
//     clk   input   rising-edge clock
//     rst   input   synchronous active-high reset / load command
//     bus   slave   serial_mult4_if: a, b (operands in), prod (product out)
//
//   Parameters:
//     WIDTH  operand width (>= 2); product is 2*WIDTH bits
//
//   Build options:
//     SERIAL_MULT_PARTIAL_EN  when defined, prod tracks the running
//                             accumulator on every compute cycle instead of
//                             staying 0 until completion.
module serial_mult4 #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  serial_mult4_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;  // wide enough to hold WIDTH
  localparam int IW = $clog2(WIDTH);      // bit-index width into b_reg
  localparam int PW = 2 * WIDTH;

  typedef enum logic {
    CALC = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    prod_reg;

  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_next;

  // Partial product for the current multiplier bit. cnt never exceeds
  // WIDTH-1 while in CALC, so the truncated index is always in range.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    addend = '0;
    if (b_reg[cnt[IW-1:0]]) begin
      addend = PW'(a_reg) << cnt;
    end
    acc_next = acc + addend;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= bus.a;
      b_reg    <= bus.b;
      acc      <= '0;
      cnt      <= '0;
      prod_reg <= '0;
      state    <= CALC;
    end else begin
      case (state)
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
`ifdef SERIAL_MULT_PARTIAL_EN
          // Expose the running sum; the last write equals the full product.
          prod_reg <= acc_next;
`endif
          if (cnt == CW'(WIDTH - 1)) begin
            prod_reg <= acc_next;
            state    <= DONE;
          end
        end
        DONE: begin
          // Result held until the next load.
        end
        default: state <= DONE;
      endcase
    end
  end

  assign bus.prod = prod_reg;

endmodule

// File: tb/tb_serial_mult4.sv
// tb_serial_mult4
//   Self-checking bench for serial_mult4 (WIDTH=4). Directed sequences,
//   a table of vectors, an exhaustive operand sweep and randomized runs with
//   operand noise and multi-cycle loads, all checked against a reference
//   built from plain arithmetic on the operands.
module tb_serial_mult4;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  serial_mult4_if #(.WIDTH(W)) bus ();

  serial_mult4 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t vecs[10];

  // Expected prod after the k-th rising edge with rst=0 following the load
  // (k=0 is the loading edge itself).
  function automatic logic [7:0] exp_prod(input logic [3:0] x,
                                          input logic [3:0] y,
                                          input int k);
    int sum;
    sum = 0;
`ifdef SERIAL_MULT_PARTIAL_EN
    for (int i = 0; i < W && i < k; i++) begin
      if (y[i]) sum = sum + int'(x) * (1 << i);
    end
`else
    if (k >= W) sum = int'(x) * int'(y);
`endif
    return 8'(sum);
  endfunction

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: prod=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Load with rst held for `hold` edges; earlier edges see junk operands,
  // the final edge captures x,y. Returns at the negedge after the last load.
  task automatic load(input logic [3:0] x, input logic [3:0] y,
                      input int hold);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      rst = 1'b1;
      if (h == hold - 1) begin
        bus.a = x;
        bus.b = y;
      end else begin
        bus.a = 4'($urandom);
        bus.b = 4'($urandom);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Follow `n` compute edges, checking prod after each against the model;
  // optionally scramble a/b to prove they are ignored.
  task automatic run(input string name, input logic [3:0] x,
                     input logic [3:0] y, input int n, input bit noise);
    for (int k = 1; k <= n; k++) begin
      if (noise) begin
        bus.a = 4'($urandom);
        bus.b = 4'($urandom);
      end
      @(negedge clk);
      check(name, bus.prod, exp_prod(x, y, k));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    bus.a    = '0;
    bus.b    = '0;

    vecs[0] = '{a: 4'd15, b: 4'd15, p: 8'hE1};
    vecs[1] = '{a: 4'd3,  b: 4'd5,  p: 8'd15};
    vecs[2] = '{a: 4'd0,  b: 4'd15, p: 8'd0};
    vecs[3] = '{a: 4'd15, b: 4'd0,  p: 8'd0};
    vecs[4] = '{a: 4'd1,  b: 4'd1,  p: 8'd1};
    vecs[5] = '{a: 4'd8,  b: 4'd8,  p: 8'd64};
    vecs[6] = '{a: 4'd10, b: 4'd12, p: 8'd120};
    vecs[7] = '{a: 4'd7,  b: 4'd9,  p: 8'd63};
    vecs[8] = '{a: 4'd1,  b: 4'd15, p: 8'd15};
    vecs[9] = '{a: 4'd15, b: 4'd8,  p: 8'd120};

    // Zero operands: prod stays 0 through and after completion.
    load(4'd0, 4'd0, 1);
    check("reset_prod", bus.prod, 8'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("zero_op", bus.prod, 8'd0);
    end

    // 3*5: latency and hold for 20 further cycles.
    load(4'd3, 4'd5, 1);
    check("load_3x5", bus.prod, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
`ifdef SERIAL_MULT_PARTIAL_EN
      check("lat_3x5", bus.prod, exp_prod(4'd3, 4'd5, k));
`else
      check("lat_3x5", bus.prod, 8'd0);
`endif
    end
    @(negedge clk);
    check("done_3x5", bus.prod, 8'd15);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("hold_3x5", bus.prod, 8'd15);
    end

    // Table vectors.
    foreach (vecs[i]) begin
      load(vecs[i].a, vecs[i].b, 1);
      check("vec_load", bus.prod, 8'd0);
      repeat (W) @(negedge clk);
      check("vec_result", bus.prod, vecs[i].p);
    end

    // Exhaustive sweep, checked 5 cycles after the load.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        load(4'(x), 4'(y), 1);
        repeat (5) @(negedge clk);
        check("sweep", bus.prod, 8'(x * y));
      end
    end

    // Operand changes during compute are ignored.
    load(4'd7, 4'd9, 1);
    bus.a = 4'd2;
    bus.b = 4'd2;
    repeat (W) @(negedge clk);
    check("ignore_ab", bus.prod, 8'd63);

    // Reset mid-operation after 2 compute edges with new operands.
    load(4'd7, 4'd9, 1);
    repeat (2) @(negedge clk);
    load(4'd6, 4'd11, 1);
    check("abort_clear", bus.prod, 8'd0);
    run("abort_restart", 4'd6, 4'd11, W, 1'b0);
    check("abort_final", bus.prod, 8'd66);

    // Reset held for several cycles: last captured pair wins.
    load(4'd13, 4'd11, 3);
    check("hold_rst_clear", bus.prod, 8'd0);
    run("hold_rst", 4'd13, 4'd11, W + 2, 1'b1);

`ifdef SERIAL_MULT_PARTIAL_EN
    // Partial products visible: 5 * 4'b1101.
    load(4'd5, 4'd13, 1);
    @(negedge clk); check("partial_e1", bus.prod, 8'd5);
    @(negedge clk); check("partial_e2", bus.prod, 8'd5);
    @(negedge clk); check("partial_e3", bus.prod, 8'd25);
    @(negedge clk); check("partial_e4", bus.prod, 8'd65);
`endif

    // Randomized: random hold length, operand noise, occasional early abort.
    for (int t = 0; t < 60; t++) begin
      logic [3:0] x;
      logic [3:0] y;
      int         n;
      x = 4'($urandom);
      y = 4'($urandom);
      load(x, y, int'($urandom_range(1, 3)));
      check("rand_load", bus.prod, 8'd0);
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1))
                                      : W + 2;
      run("rand", x, y, n, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_mult4.md
# serial_mult4

Shift-and-add serial multiplier producing the unsigned product of two WIDTH-bit operands over WIDTH clock cycles, one multiplier bit per cycle. Asserting the synchronous reset both clears the block and captures a new operand pair, so `rst` doubles as the start strobe. Used as a small-area arithmetic unit where throughput of one product per WIDTH+1 cycles is sufficient.

## Interface
Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset; also the load/start command.
- a  input  WIDTH  multiplicand, unsigned; sampled only on a clock edge with rst=1.
- b  input  WIDTH  multiplier, unsigned; sampled only on a clock edge with rst=1.
- prod  output  2*WIDTH  product a*b; registered.

## Operation
- Internal registers: a_reg (WIDTH), b_reg (WIDTH), acc (2*WIDTH), cnt ($clog2(WIDTH)+1 bits), state {CALC, DONE}.
- Rising edge with rst=1: a_reg<=a, b_reg<=b, acc<=0, cnt<=0, prod<=0, state<=CALC. Reset takes priority over everything else.
- CALC, each edge with rst=0: acc <= acc + (b_reg[cnt] ? (a_reg << cnt) : 0), zero-extended to 2*WIDTH; cnt<=cnt+1.
- On the CALC edge where cnt==WIDTH-1: prod <= final acc value (including this cycle's addend); state<=DONE.
- DONE: all registers hold; prod holds a*b indefinitely until next rst. No further additions, cnt does not wrap.
- Arithmetic: unsigned; 2*WIDTH-bit acc cannot overflow (max (2^W-1)^2).
- a/b changes while rst=0 have no effect.
- rst asserted mid-computation: current operation abandoned, new operands captured, prod<=0, restart from cnt=0.
- rst held high for several cycles: reloads every edge; computation begins on first edge with rst=0.
- No state is undefined after the first reset edge; power-up values before any reset are don't-care.

## Timing
- Reset values: prod=0, acc=0, cnt=0, state=CALC.
- Latency: prod valid after the WIDTH-th rising edge with rst=0 following the loading edge (4 edges for WIDTH=4).
- Between load and completion prod reads 0 (unless SERIAL_MULT_PARTIAL_EN, below).
- Minimum operation period: 1 load cycle + WIDTH compute cycles (5 cycles for WIDTH=4).
- No combinational path from inputs to prod.

## Configuration
- SERIAL_MULT_PARTIAL_EN defined: prod is updated every CALC cycle with the new running acc value (partial product visible, monotonically non-decreasing, final value identical); reset still clears prod to 0.
- Not defined: prod written only on the completing edge, as in Operation; 0 during calculation.

## Test plan
- Load a=0,b=0 via one-cycle rst, then 5 idle cycles -> prod=0 throughout and after completion.
- Load a=3,b=5 -> prod=0 for edges 1-3 after release, prod=15 from edge 4 onward, held 20 further cycles.
- Load a=15,b=15 -> prod=225 (8'hE1) after 4 edges; no overflow.
- Exhaustive sweep: every a,b in 0..15, each loaded with a 1-cycle rst and checked 5 cycles later -> prod==a*b for all 256 pairs.
- Load a=7,b=9, change a=2,b=2 during compute -> prod=63; then rst mid-operation (after 2 edges) with a=6,b=11 -> prod=0 at reset edge, 66 four edges after release.
- With SERIAL_MULT_PARTIAL_EN: load a=5,b=13 (1101) -> prod sequence 5,5,25,65 on edges 1-4.
